// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR conversion sequencer.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SETTLE,
    DECIDE,
    DONE
  } sar_state_t;

  localparam int DEF_N_BITS        = 8;
  localparam int DEF_SAMPLE_CYCLES = 100;
  localparam int DEF_SETTLE_CYCLES = 4;

  // One down-counter serves both the acquisition and the settle windows.
  function automatic int cnt_width(input int sample_cycles, input int settle_cycles);
    int longest;
    longest = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/sar_sequencer_if.sv
// Converter-side and readout-side signals of the SAR sequencer.
interface sar_sequencer_if
  import sar_pkg::*;
#(
  parameter int N_BITS = DEF_N_BITS
);
  logic              abort;
  logic              comp_in;
  logic              hold;
  logic [N_BITS-1:0] dac_code;
  logic              busy;
  logic              eoc;
  logic [N_BITS-1:0] data_out;
  logic              overrun;

  modport master (
    input  abort, comp_in,
    output hold, dac_code, busy, eoc, data_out, overrun
  );

  modport slave (
    output abort, comp_in,
    input  hold, dac_code, busy, eoc, data_out, overrun
  );
endinterface

// File: rtl/sar_sync2.sv
// Two-flop synchronizer with a selectable reset level.
module sar_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end
endmodule

// File: rtl/sar_sequencer.sv
// Successive-approximation conversion controller: edge-triggered start,
// fixed acquisition window, then one trial bit per settle+decide slot.
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int N_BITS        = DEF_N_BITS,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic            clk50,
  input  logic            rst_n,
  input  logic            clk,
  sar_sequencer_if.master bus
);
  localparam int CNT_W = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [N_BITS-1:0] ONE = N_BITS'(1);
  localparam logic [N_BITS-1:0] MSB = ONE << (N_BITS - 1);

  logic              clk_s, clk_hist_reg, start_edge, comp_s;
  sar_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [N_BITS-1:0] result_reg, result_next;
  logic [N_BITS-1:0] dac_reg, dac_next;
  logic [N_BITS-1:0] data_reg, data_next;
  logic              overrun_reg, overrun_next;
  logic              hold, busy, eoc;

  // Sync and history reset high so a level already high at reset release is not an edge.
  sar_sync2 #(.RST_VAL(1'b1)) u_clk_sync (.clk(clk50), .rst_n(rst_n), .d(clk), .q(clk_s));
  sar_sync2 #(.RST_VAL(1'b0)) u_comp_sync (.clk(clk50), .rst_n(rst_n), .d(bus.comp_in), .q(comp_s));

  assign start_edge = clk_s & ~clk_hist_reg;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      clk_hist_reg <= 1'b1;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      result_reg   <= '0;
      dac_reg      <= '0;
      data_reg     <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      clk_hist_reg <= clk_s;
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      result_reg   <= result_next;
      dac_reg      <= dac_next;
      data_reg     <= data_next;
      overrun_reg  <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    result_next  = result_reg;
    dac_next     = dac_reg;
    data_next    = data_reg;
    overrun_next = overrun_reg;

    if (start_edge && state_reg != IDLE) overrun_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next   = SAMPLE;
          cnt_next     = CNT_W'(SAMPLE_CYCLES - 1);
          result_next  = '0;
          overrun_next = 1'b0;
        end
      end
      SAMPLE: begin
        if (cnt_reg == '0) begin
          state_next = SETTLE;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
          idx_next   = IDX_W'(N_BITS - 1);
          dac_next   = MSB;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) state_next = DECIDE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      DECIDE: begin
        result_next[idx_reg] = comp_s;
        if (idx_reg != '0) begin
          state_next = SETTLE;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
          idx_next   = idx_reg - IDX_W'(1);
          dac_next   = result_next | (ONE << (idx_reg - IDX_W'(1)));
        end else begin
          state_next = DONE;
          data_next  = result_next;
        end
      end
      DONE: begin
        state_next = IDLE;
        dac_next   = '0;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over the state's own transition and leaves overrun and data_out alone.
    if (bus.abort && (state_reg == SAMPLE || state_reg == SETTLE || state_reg == DECIDE)) begin
      state_next = IDLE;
      dac_next   = '0;
      data_next  = data_reg;
    end
  end

  always_comb begin
    hold = 1'b0;
    busy = 1'b0;
    eoc  = 1'b0;
    case (state_reg)
      SAMPLE:         busy = 1'b1;
      SETTLE, DECIDE: begin busy = 1'b1; hold = 1'b1; end
      DONE:           begin busy = 1'b1; hold = 1'b1; eoc = 1'b1; end
      default:        ;
    endcase
  end

  assign bus.hold     = hold;
  assign bus.busy     = busy;
  assign bus.eoc      = eoc;
  assign bus.dac_code = dac_reg;
  assign bus.data_out = data_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_sar_sequencer.sv
// Directed bench for sar_sequencer with ideal DAC/comparator models and a result scoreboard.
module tb_sar_sequencer;
  localparam int NB   = 8;
  localparam int SC_A = 100;
  localparam int ST_A = 4;
  localparam int SC_B = 5;
  localparam int ST_B = 3;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_a = 1'b0;
  logic       clk_b = 1'b0;
  logic       abort_a = 1'b0;
  logic       abort_b = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] vin = 8'h00;
  logic       comp_b_reg;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] code_q[$];
  logic [7:0] data_q[$];
  logic [7:0] last_data = 8'h00;

  always #10 clk50 = ~clk50;

  sar_sequencer_if #(.N_BITS(NB)) bus_a ();
  sar_sequencer_if #(.N_BITS(NB)) bus_b ();

  // Converter A: comparator follows the DAC combinationally.
  assign bus_a.abort   = abort_a;
  assign bus_a.comp_in = (vin >= bus_a.dac_code);
  // Converter B: comparator answers one clk50 cycle after the DAC code changes.
  assign bus_b.abort   = abort_b;
  assign bus_b.comp_in = comp_b_reg;
  always @(posedge clk50) comp_b_reg <= (vin >= bus_b.dac_code);

  sar_sequencer #(.N_BITS(NB), .SAMPLE_CYCLES(SC_A), .SETTLE_CYCLES(ST_A)) dut_a (
    .clk50(clk50), .rst_n(rst_n), .clk(clk_a), .bus(bus_a.master)
  );
  sar_sequencer #(.N_BITS(NB), .SAMPLE_CYCLES(SC_B), .SETTLE_CYCLES(ST_B)) dut_b (
    .clk50(clk50), .rst_n(rst_n), .clk(clk_b), .bus(bus_b.master)
  );

  logic [7:0] m_dac, m_data;
  logic       m_hold, m_busy, m_eoc, m_ovr;
  assign m_dac  = sel ? bus_b.dac_code : bus_a.dac_code;
  assign m_data = sel ? bus_b.data_out : bus_a.data_out;
  assign m_hold = sel ? bus_b.hold     : bus_a.hold;
  assign m_busy = sel ? bus_b.busy     : bus_a.busy;
  assign m_eoc  = sel ? bus_b.eoc      : bus_a.eoc;
  assign m_ovr  = sel ? bus_b.overrun  : bus_a.overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic set_clk(input logic v);
    if (sel) clk_b = v;
    else     clk_a = v;
  endtask

  task automatic set_abort(input logic v);
    if (sel) abort_b = v;
    else     abort_a = v;
  endtask

  // Binary-search reference: trial codes and final code for an ideal converter.
  task automatic push_expected(input logic [7:0] v, input bit keep_data);
    logic [7:0] code;
    logic [7:0] trial;
    code = 8'h00;
    for (int i = NB - 1; i >= 0; i--) begin
      trial = code | (8'd1 << i);
      code_q.push_back(trial);
      if (v >= trial) code = trial;
    end
    if (keep_data) begin
      data_q.push_back(code);
      last_data = code;
    end
  endtask

  // One conversion; k counts clk50 edges after the conversion clock rises, so T0 is k=3.
  task automatic convert(input bit s, input logic [7:0] v, input int second_at, input int abort_at);
    int sc, st, first_k, eoc_k, last_k;
    int hold_cnt, eoc_cnt, ncode;
    logic [7:0] prev_dac;
    sel      = s;
    vin      = v;
    sc       = s ? SC_B : SC_A;
    st       = s ? ST_B : ST_A;
    first_k  = 3 + sc;
    eoc_k    = first_k + NB * (st + 1);
    last_k   = (abort_at > 0) ? abort_at + 30 : eoc_k + 1;
    hold_cnt = 0;
    eoc_cnt  = 0;
    ncode    = 0;
    code_q.delete();
    push_expected(v, abort_at <= 0);
    #1;
    prev_dac = m_dac;
    @(negedge clk50);
    set_clk(1'b1);
    for (int k = 1; k <= last_k; k++) begin
      step();
      if (k == 10) set_clk(1'b0);
      if (second_at > 0 && k == second_at) set_clk(1'b1);
      if (second_at > 0 && k == second_at + 10) set_clk(1'b0);
      if (k == 2) check("idle_before_t0", m_busy, 1'b0);
      if (k == 3) begin
        check("busy_at_t0", m_busy, 1'b1);
        check("overrun_clr_t0", m_ovr, 1'b0);
      end
      if (m_dac != prev_dac && m_dac != 8'h00) begin
        if (code_q.size() == 0) begin
          check("code_unexpected", m_dac, 8'h00);
        end else begin
          check("trial_code", m_dac, code_q.pop_front());
          check("trial_time", k, first_k + ncode * (st + 1));
          ncode++;
        end
      end
      prev_dac = m_dac;
      hold_cnt += int'(m_hold);
      if (m_eoc) begin
        eoc_cnt++;
        if (data_q.size() == 0) begin
          check("eoc_unexpected", m_eoc, 1'b0);
        end else begin
          check("eoc_time", k, eoc_k);
          check("data_out", m_data, data_q.pop_front());
        end
      end
      if (abort_at > 0 && k == abort_at) set_abort(1'b1);
      if (abort_at > 0 && k == abort_at + 1) begin
        set_abort(1'b0);
        check("abort_idle", {m_busy, m_hold, m_dac}, 0);
        code_q.delete();
      end
    end
    if (abort_at > 0) begin
      check("abort_no_eoc", eoc_cnt, 0);
      check("abort_data_kept", m_data, last_data);
      check("abort_overrun", m_ovr, 1'b0);
    end else begin
      check("eoc_pulses", eoc_cnt, 1);
      check("hold_cycles", hold_cnt, NB * (st + 1) + 1);
      check("idle_after_eoc", {m_busy, m_hold, m_eoc}, 0);
      check("codes_seen", ncode, NB);
      check("overrun_end", m_ovr, second_at > 0);
      check("data_held", m_data, last_data);
    end
    $display("conv dut=%0d vin=%02h exp=%02h got=%02h overrun=%0b", s, v, last_data, m_data, m_ovr);
    repeat (5) step();
  endtask

  initial begin
    int busy_cnt;
    // Reset state of both converters.
    repeat (3) @(posedge clk50);
    #1;
    sel = 1'b0;
    #1;
    check("reset_a", {m_hold, m_dac, m_busy, m_eoc, m_data, m_ovr}, 0);
    sel = 1'b1;
    #1;
    check("reset_b", {m_hold, m_dac, m_busy, m_eoc, m_data, m_ovr}, 0);
    sel = 1'b0;
    rst_n = 1'b1;
    repeat (5) step();

    convert(1'b0, 8'hA5, -1, -1);
    convert(1'b0, 8'h00, -1, -1);
    convert(1'b0, 8'hFF, -1, -1);
    convert(1'b0, 8'hA5, 110, -1);
    convert(1'b0, 8'h3C, -1, 123);

    // Reset mid-SETTLE with overrun set, conversion clock left high through release.
    sel = 1'b0;
    vin = 8'h77;
    @(negedge clk50);
    clk_a = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      step();
      if (k == 10)  clk_a = 1'b0;
      if (k == 100) clk_a = 1'b1;
    end
    check("pre_reset_overrun", m_ovr, 1'b1);
    check("pre_reset_data", m_data, last_data);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_settle", {m_hold, m_dac, m_busy, m_eoc, m_data, m_ovr}, 0);
    last_data = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      busy_cnt += int'(m_busy);
    end
    check("no_start_high_at_release", busy_cnt, 0);
    clk_a = 1'b0;
    repeat (5) step();
    convert(1'b0, 8'h5A, -1, -1);

    // Shorter settle window against the slower comparator.
    convert(1'b1, 8'h55, -1, -1);
    convert(1'b1, 8'hAA, -1, -1);
    convert(1'b1, 8'h01, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
